sram_ctrl_top: RTL and testbench
================================

SRAM_CTRL_TOP -- requirements
Module: sram_ctrl_top

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning word width in bits (multiple of 8).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 12, meaning word-address width.
REQ-003 The block SHALL have parameter DEPTH, default 2**ADDR_WIDTH, meaning number of implemented words (1..2**ADDR_WIDTH).
REQ-004 The block SHALL have parameter READ_LATENCY, default 1, meaning cycles from read accept to response (legal 1..4).
REQ-005 The block SHALL have parameter INIT_ZERO, default 1, meaning 1 = scrub memory to zero after reset.
REQ-006 Ports SHALL be, in order:
- clk_i  in  1  sole clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  1  request.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  ADDR_WIDTH  word address.
- wdata_i  in  DATA_WIDTH  write data.
- wmask_i  in  DATA_WIDTH/8  byte write enables.
- gnt_o  out  1  request accepted this cycle.
- rvalid_o  out  1  read response valid.
- rdata_o  out  DATA_WIDTH  read data.
- err_o  out  1  out-of-range access flag.
- init_done_o  out  1  scrub complete, block serviceable.
REQ-007 Storage SHALL be the team sram macro: NUM_WMASKS=DATA_WIDTH/8, clocked on ~clk_i, port 1 tied off (clk1=0, csb1=1, addr1=0).

Function
REQ-008 FSM states SHALL be INIT and READY; reset enters INIT when INIT_ZERO=1, else READY.
REQ-009 In INIT, a counter from 0 SHALL write all-zero data with full mask to one address per cycle, through DEPTH-1.
REQ-010 After the write to DEPTH-1, the FSM SHALL move to READY on the next edge; INIT lasts exactly DEPTH cycles.
REQ-011 init_done_o SHALL be 1 exactly when in READY.
REQ-012 gnt_o SHALL equal req_i when in READY, and 0 when in INIT (requests stall; no queuing).
REQ-013 A request is accepted on a rising edge with req_i=1 and gnt_o=1; one access per cycle.
REQ-014 An accepted in-range write (addr_i < DEPTH) SHALL update only bytes with wmask_i=1 and produce no rvalid_o.
REQ-015 An accepted in-range read at edge N SHALL give rvalid_o=1 for exactly one cycle starting at edge N+READ_LATENCY.
REQ-016 rdata_o SHALL be valid only while rvalid_o=1; with READ_LATENCY=1, rdata_o comes directly from the macro output.
REQ-017 The response pipeline SHALL accept back-to-back reads; responses SHALL return in order, one per cycle, with no bubbles.
REQ-018 A write accepted the edge before a read to the same address SHALL be visible to that read.
REQ-019 An accepted read with addr_i >= DEPTH SHALL NOT access the macro, and SHALL return rvalid_o=1, err_o=1, rdata_o=0 at the same latency.
REQ-020 An accepted write with addr_i >= DEPTH SHALL be dropped, and err_o SHALL pulse for one cycle at edge N+1 with rvalid_o=0.
REQ-021 If a read error and a write error fall due in the same cycle, err_o SHALL be 1 for that cycle.
REQ-022 Macro chip-select SHALL be active only for accepted in-range requests or INIT writes.

Reset
REQ-023 Asserting rst_ni low at any time SHALL immediately force:
- rvalid_o=0, err_o=0, rdata_o=0, gnt_o=0, init_done_o=0;
- all response-pipeline valid bits cleared;
- scrub counter to 0.
REQ-024 A reset during INIT SHALL restart the scrub from address 0.
REQ-025 Reads in flight when reset asserts SHALL be discarded with no response.
REQ-026 With INIT_ZERO=0, memory contents after reset are unspecified; init_done_o=1 on the first edge after rst_ni deasserts.

Verification
REQ-027 Reset, INIT_ZERO=1, DEPTH=16: init_done_o=0 for 16 cycles, then 1; read of address 5 -> rdata_o=0x00000000.
REQ-028 Write 0xDEADBEEF, mask 4'b1111, to 0x010; then write 0x00001234, mask 4'b0011, to 0x010; then read 0x010 -> rdata_o=0xDEAD1234.
REQ-029 READ_LATENCY=3, reads to 1,2,3 on consecutive edges N..N+2 -> rvalid_o high at N+3..N+5 with data in order.
REQ-030 DEPTH=3000: read 0xFFF -> rvalid_o=1, err_o=1, rdata_o=0 after READ_LATENCY; write 0xFFF -> err_o pulse at N+1, memory unchanged.
REQ-031 Two requests, both behaviours:
- req_i=1 during INIT -> gnt_o=0 and no rvalid_o until init_done_o=1;
- rst_ni pulsed low mid-INIT -> INIT restarts and lasts a full DEPTH cycles.
REQ-032 Read accepted at N, rst_ni low at N+1 with READ_LATENCY=2 -> no rvalid_o pulse occurs.

Source files
------------

// File: rtl/sram_ctrl_top.sv
// Single-port SRAM controller: post-reset zero scrub, byte-masked writes, fixed-latency
// in-order read responses and out-of-range error reporting, around the team sram macro.

module sram_ctrl_macro #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096,
    parameter int NUM_WMASKS = 4
) (
    input  logic                  clk0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    input  logic                  clk1,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  csb0_q;
    logic                  web0_q;
    logic [NUM_WMASKS-1:0] wmask0_q;
    logic [ADDR_WIDTH-1:0] addr0_q;
    logic [DATA_WIDTH-1:0] din0_q;
    logic                  csb1_q;
    logic [ADDR_WIDTH-1:0] addr1_q;

    // Inputs are captured on the rising edge and the array is accessed on the falling edge.
    always_ff @(posedge clk0) begin
        csb0_q   <= csb0;
        web0_q   <= web0;
        wmask0_q <= wmask0;
        addr0_q  <= addr0;
        din0_q   <= din0;
    end

    always_ff @(negedge clk0) begin
        if (!csb0_q && !web0_q) begin
            for (int b = 0; b < NUM_WMASKS; b++) begin
                if (wmask0_q[b]) begin
                    mem[addr0_q][b*8 +: 8] <= din0_q[b*8 +: 8];
                end
            end
        end
        if (!csb0_q && web0_q) begin
            dout0 <= mem[addr0_q];
        end
    end

    always_ff @(posedge clk1) begin
        csb1_q  <= csb1;
        addr1_q <= addr1;
    end

    always_ff @(negedge clk1) begin
        if (!csb1_q) begin
            dout1 <= mem[addr1_q];
        end
    end
endmodule

module sram_ctrl_top #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 12,
    parameter int DEPTH        = 2**ADDR_WIDTH,
    parameter int READ_LATENCY = 1,
    parameter bit INIT_ZERO    = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wmask_i,
    output logic                    gnt_o,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    output logic                    init_done_o
);
    localparam int NUM_WMASKS = DATA_WIDTH / 8;
    localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             live_q;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    logic                  cmd_en_q, cmd_en_d;
    logic                  cmd_we_q, cmd_we_d;
    logic [IDX_W-1:0]      cmd_addr_q, cmd_addr_d;
    logic [DATA_WIDTH-1:0] cmd_din_q, cmd_din_d;
    logic [NUM_WMASKS-1:0] cmd_mask_q, cmd_mask_d;

    logic                    rd_q, rd_oor_q, wr_oor_q;
    logic [READ_LATENCY:1]   vld_q, rerr_q;
    logic                    werr_q;

    logic                  in_range;
    logic                  accept;
    logic                  sram_clk;
    logic [DATA_WIDTH-1:0] sram_dout;
    logic [DATA_WIDTH-1:0] unused_dout1;

    // live_q keeps the block unserviceable while reset is held, even when no scrub is needed.
    assign init_done_o = live_q && (state_q == ST_READY);
    assign gnt_o       = req_i && init_done_o;
    assign accept      = req_i && gnt_o;
    assign in_range    = ({1'b0, addr_i} < DEPTH_EXT);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_en_d   = 1'b0;
        cmd_we_d   = 1'b0;
        cmd_addr_d = addr_i[IDX_W-1:0];
        cmd_din_d  = wdata_i;
        cmd_mask_d = wmask_i;
        case (state_q)
            ST_INIT: begin
                cmd_en_d   = 1'b1;
                cmd_we_d   = 1'b1;
                cmd_addr_d = cnt_q;
                cmd_din_d  = '0;
                cmd_mask_d = '1;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end
            end
            ST_READY: begin
                cmd_en_d = accept && in_range;
                cmd_we_d = we_i;
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= INIT_ZERO ? ST_INIT : ST_READY;
            live_q     <= 1'b0;
            cnt_q      <= '0;
            cmd_en_q   <= 1'b0;
            cmd_we_q   <= 1'b0;
            cmd_addr_q <= '0;
            cmd_din_q  <= '0;
            cmd_mask_q <= '0;
            rd_q       <= 1'b0;
            rd_oor_q   <= 1'b0;
            wr_oor_q   <= 1'b0;
            vld_q      <= '0;
            rerr_q     <= '0;
            werr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            live_q     <= 1'b1;
            cnt_q      <= cnt_d;
            cmd_en_q   <= cmd_en_d;
            cmd_we_q   <= cmd_we_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_din_q  <= cmd_din_d;
            cmd_mask_q <= cmd_mask_d;
            rd_q       <= accept && !we_i;
            rd_oor_q   <= accept && !we_i && !in_range;
            wr_oor_q   <= accept && we_i && !in_range;
            // Stage 1 lines up with the macro output; later stages only add delay.
            vld_q[1]   <= rd_q;
            rerr_q[1]  <= rd_oor_q;
            for (int k = 2; k <= READ_LATENCY; k++) begin
                vld_q[k]  <= vld_q[k-1];
                rerr_q[k] <= rerr_q[k-1];
            end
            werr_q     <= wr_oor_q;
        end
    end

    assign rvalid_o = vld_q[READ_LATENCY];
    assign err_o    = (vld_q[READ_LATENCY] && rerr_q[READ_LATENCY]) || werr_q;

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign rdata_o = (vld_q[1] && !rerr_q[1]) ? sram_dout : '0;
        end else begin : g_latn
            logic [DATA_WIDTH-1:0] dat_q [2:READ_LATENCY];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int k = 2; k <= READ_LATENCY; k++) begin
                        dat_q[k] <= '0;
                    end
                end else begin
                    dat_q[2] <= (vld_q[1] && !rerr_q[1]) ? sram_dout : '0;
                    for (int k = 3; k <= READ_LATENCY; k++) begin
                        dat_q[k] <= dat_q[k-1];
                    end
                end
            end

            assign rdata_o = vld_q[READ_LATENCY] ? dat_q[READ_LATENCY] : '0;
        end
    endgenerate

    assign sram_clk = ~clk_i;

    sram_ctrl_macro #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (IDX_W),
        .DEPTH      (DEPTH),
        .NUM_WMASKS (NUM_WMASKS)
    ) u_sram (
        .clk0   (sram_clk),
        .csb0   (~cmd_en_q),
        .web0   (~cmd_we_q),
        .wmask0 (cmd_mask_q),
        .addr0  (cmd_addr_q),
        .din0   (cmd_din_q),
        .dout0  (sram_dout),
        .clk1   (1'b0),
        .csb1   (1'b1),
        .addr1  ('0),
        .dout1  (unused_dout1)
    );
endmodule

// File: tb/tb_sram_ctrl_top.sv
// Directed bench for sram_ctrl_top: three instances cover scrub timing, masked writes,
// latency 1/2/3 response timing, out-of-range errors and reset behaviour.

module tb_sram_ctrl_top;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst16_n, rst3k_n, rst2_n;
    logic        req, we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;

    logic        a_gnt, a_rv, a_err, a_done;
    logic [31:0] a_rdata;
    logic        b_gnt, b_rv, b_err, b_done;
    logic [31:0] b_rdata;
    logic        c_gnt, c_rv, c_err, c_done;
    logic [31:0] c_rdata;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [31:0] seq_d [3] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};

    sram_ctrl_top #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(16), .READ_LATENCY(1), .INIT_ZERO(1'b1)) u_d16 (
        .clk_i(clk), .rst_ni(rst16_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .wmask_i(wmask), .gnt_o(a_gnt), .rvalid_o(a_rv), .rdata_o(a_rdata), .err_o(a_err),
        .init_done_o(a_done));

    sram_ctrl_top #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(3000), .READ_LATENCY(3), .INIT_ZERO(1'b1)) u_d3k (
        .clk_i(clk), .rst_ni(rst3k_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .wmask_i(wmask), .gnt_o(b_gnt), .rvalid_o(b_rv), .rdata_o(b_rdata), .err_o(b_err),
        .init_done_o(b_done));

    sram_ctrl_top #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(16), .READ_LATENCY(2), .INIT_ZERO(1'b0)) u_d2 (
        .clk_i(clk), .rst_ni(rst2_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .wmask_i(wmask), .gnt_o(c_gnt), .rvalid_o(c_rv), .rdata_o(c_rdata), .err_o(c_err),
        .init_done_o(c_done));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [11:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        req   = r;
        we    = w;
        addr  = a;
        wdata = d;
        wmask = m;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    endtask

    // Counts sampled cycles with init_done_o low on instance 0 (d16) or 1 (d3k).
    task automatic count_init(input int which, input int bound, output int zeros,
                              output logic gnt_seen, output logic rv_seen);
        zeros    = 0;
        gnt_seen = 1'b0;
        rv_seen  = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if ((which == 0) ? a_done : b_done) break;
            zeros++;
            gnt_seen = gnt_seen | ((which == 0) ? a_gnt : b_gnt);
            rv_seen  = rv_seen  | ((which == 0) ? a_rv  : b_rv);
            cyc();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int   zeros;
        logic gs, rs;

        rst16_n = 1'b0;
        rst3k_n = 1'b0;
        rst2_n  = 1'b0;
        drive(1'b1, 1'b0, 12'h005, 32'h0, 4'h0);
        #2;
        chk("rst_done",     32'(a_done),  32'd0);
        chk("rst_gnt",      32'(a_gnt),   32'd0);
        chk("rst_rvalid",   32'(a_rv),    32'd0);
        chk("rst_err",      32'(a_err),   32'd0);
        chk("rst_rdata",    a_rdata,      32'd0);
        chk("rst_nz_done",  32'(c_done),  32'd0);
        chk("rst_nz_gnt",   32'(c_gnt),   32'd0);
        cyc();
        cyc();

        // Scrub of 16 words with a read held pending the whole time.
        rst16_n = 1'b1;
        count_init(0, 100, zeros, gs, rs);
        chk("init16_len",    32'(zeros), 32'd16);
        chk("init16_gnt",    32'(gs),    32'd0);
        chk("init16_rvalid", 32'(rs),    32'd0);
        chk("ready_gnt",     32'(a_gnt), 32'd1);
        cyc();
        idle();
        chk("rd5_rv_early",  32'(a_rv),  32'd0);
        cyc();
        chk("rd5_rv",        32'(a_rv),  32'd1);
        chk("rd5_data",      a_rdata,    32'h0000_0000);
        chk("rd5_err",       32'(a_err), 32'd0);
        cyc();
        chk("rd5_rv_once",   32'(a_rv),  32'd0);

        // Masked write then read in the very next cycle.
        drive(1'b1, 1'b1, 12'h003, 32'hA5A5_A5A5, 4'hF);
        cyc();
        chk("wr_no_rv",      32'(a_rv),  32'd0);
        drive(1'b1, 1'b1, 12'h003, 32'h1234_56FF, 4'h1);
        cyc();
        chk("wr_no_err",     32'(a_err), 32'd0);
        drive(1'b1, 1'b0, 12'h003, 32'h0, 4'h0);
        cyc();
        idle();
        chk("rd3_rv_early",  32'(a_rv),  32'd0);
        cyc();
        chk("rd3_rv",        32'(a_rv),  32'd1);
        chk("rd3_data",      a_rdata,    32'hA5A5_A5FF);

        // Reset while ready, then a second reset partway through the scrub.
        drive(1'b1, 1'b0, 12'h005, 32'h0, 4'h0);
        rst16_n = 1'b0;
        #1;
        chk("rst_async_done", 32'(a_done), 32'd0);
        chk("rst_async_gnt",  32'(a_gnt),  32'd0);
        rst16_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        chk("mid_init_done",  32'(a_done), 32'd0);
        rst16_n = 1'b0;
        #1;
        rst16_n = 1'b1;
        count_init(0, 100, zeros, gs, rs);
        chk("reinit16_len",    32'(zeros), 32'd16);
        chk("reinit16_gnt",    32'(gs),    32'd0);
        chk("reinit16_rvalid", 32'(rs),    32'd0);
        idle();

        // DEPTH=3000, READ_LATENCY=3 instance.
        rst3k_n = 1'b1;
        count_init(1, 4000, zeros, gs, rs);
        chk("init3k_len", 32'(zeros), 32'd3000);

        drive(1'b1, 1'b1, 12'h010, 32'hDEAD_BEEF, 4'hF);
        cyc();
        drive(1'b1, 1'b1, 12'h010, 32'h0000_1234, 4'h3);
        cyc();
        drive(1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
        cyc();
        idle();
        for (int c = 0; c < 3; c++) begin
            chk("rd10_rv_early", 32'(b_rv), 32'd0);
            cyc();
        end
        chk("rd10_rv",   32'(b_rv),  32'd1);
        chk("rd10_data", b_rdata,    32'hDEAD_1234);
        chk("rd10_err",  32'(b_err), 32'd0);
        cyc();
        chk("rd10_rv_once", 32'(b_rv), 32'd0);

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 12'(i + 1), seq_d[i], 4'hF);
            cyc();
        end
        for (int c = 0; c < 7; c++) begin
            if (c < 3) drive(1'b1, 1'b0, 12'(c + 1), 32'h0, 4'h0);
            else idle();
            cyc();
            chk("b2b_rv", 32'(b_rv), (c >= 3 && c <= 5) ? 32'd1 : 32'd0);
            if (c >= 3 && c <= 5) chk("b2b_data", b_rdata, seq_d[c-3]);
        end

        drive(1'b1, 1'b0, 12'hFFF, 32'h0, 4'h0);
        cyc();
        idle();
        for (int c = 0; c < 3; c++) begin
            chk("oor_rd_err_early", 32'(b_err), 32'd0);
            cyc();
        end
        chk("oor_rd_rv",    32'(b_rv),  32'd1);
        chk("oor_rd_err",   32'(b_err), 32'd1);
        chk("oor_rd_data",  b_rdata,    32'd0);
        cyc();
        chk("oor_rd_err_once", 32'(b_err), 32'd0);

        drive(1'b1, 1'b1, 12'hFFF, 32'hCAFE_F00D, 4'hF);
        cyc();
        idle();
        chk("oor_wr_err_early", 32'(b_err), 32'd0);
        cyc();
        chk("oor_wr_err",   32'(b_err), 32'd1);
        chk("oor_wr_no_rv", 32'(b_rv),  32'd0);
        cyc();
        chk("oor_wr_err_once", 32'(b_err), 32'd0);

        drive(1'b1, 1'b0, 12'h7FF, 32'h0, 4'h0);
        cyc();
        drive(1'b1, 1'b0, 12'h447, 32'h0, 4'h0);
        cyc();
        idle();
        cyc();
        cyc();
        chk("alias7ff_rv",   32'(b_rv), 32'd1);
        chk("alias7ff_data", b_rdata,   32'd0);
        cyc();
        chk("alias447_rv",   32'(b_rv), 32'd1);
        chk("alias447_data", b_rdata,   32'd0);

        drive(1'b1, 1'b0, 12'hFFF, 32'h0, 4'h0);
        cyc();
        idle();
        cyc();
        drive(1'b1, 1'b1, 12'hFFF, 32'h5555_5555, 4'hF);
        cyc();
        idle();
        chk("both_err_early", 32'(b_err), 32'd0);
        cyc();
        chk("both_err",    32'(b_err), 32'd1);
        chk("both_err_rv", 32'(b_rv),  32'd1);
        cyc();
        chk("both_err_once", 32'(b_err), 32'd0);

        // INIT_ZERO=0, READ_LATENCY=2 instance.
        rst2_n = 1'b1;
        chk("nz_done_pre", 32'(c_done), 32'd0);
        cyc();
        chk("nz_done", 32'(c_done), 32'd1);
        drive(1'b1, 1'b1, 12'h007, 32'h0BAD_F00D, 4'hF);
        cyc();
        drive(1'b1, 1'b0, 12'h007, 32'h0, 4'h0);
        cyc();
        idle();
        chk("l2_rv_n0", 32'(c_rv), 32'd0);
        cyc();
        chk("l2_rv_n1", 32'(c_rv), 32'd0);
        cyc();
        chk("l2_rv",   32'(c_rv), 32'd1);
        chk("l2_data", c_rdata,   32'h0BAD_F00D);

        drive(1'b1, 1'b0, 12'h007, 32'h0, 4'h0);
        cyc();
        idle();
        cyc();
        drive(1'b1, 1'b0, 12'h007, 32'h0, 4'h0);
        rst2_n = 1'b0;
        #1;
        chk("flush_rst_rv",   32'(c_rv),   32'd0);
        chk("flush_rst_gnt",  32'(c_gnt),  32'd0);
        chk("flush_rst_done", 32'(c_done), 32'd0);
        idle();
        rst2_n = 1'b1;
        rs = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            rs = rs | c_rv;
        end
        chk("flush_no_rv", 32'(rs), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
